// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the external-memory sequencer: request types,
// sequencer state encoding and a small sizing helper.
package mem_bus_ctrl_pkg;

  // Request type as issued by the core state machine
  typedef enum logic [1:0] {
    TYPE_IDLE       = 2'd0,
    TYPE_IMEM_READ  = 2'd1,
    TYPE_DMEM_READ  = 2'd2,
    TYPE_DMEM_WRITE = 2'd3
  } mem_type_t;

  // Sequencer states kept as plain constants so older tools can share them
  typedef logic [2:0] bus_state_t;
  localparam bus_state_t BUS_IDLE     = 3'd0;
  localparam bus_state_t BUS_ADDR     = 3'd1;
  localparam bus_state_t BUS_WDATA    = 3'd2;
  localparam bus_state_t BUS_WAIT_ACK = 3'd3;
  localparam bus_state_t BUS_RDATA    = 3'd4;
  localparam bus_state_t BUS_RESP     = 3'd5;

  // Larger of two beat counts, used to size the shared beat counter
  function automatic int maxBeats(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response and external bus signals of the memory sequencer.
// The master modport is the sequencer itself (it masters the off-chip bus);
// the slave modport is the environment (core plus memory device).
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BUS_W  = 4
) ();
  import mem_bus_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  mem_type_t         req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  mem_type_t         bus_type;
  logic [BUS_W-1:0]  bus_out;
  logic              bus_oe;
  logic [BUS_W-1:0]  bus_in;
  logic              bus_ack;
  logic              busy;

  modport master (
    input  req_valid, req_type, req_addr, req_wdata, bus_in, bus_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_type, bus_out, bus_oe, busy
  );

  modport slave (
    output req_valid, req_type, req_addr, req_wdata, bus_in, bus_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_type, bus_out, bus_oe, busy
  );

endinterface

// File: rtl/mem_bus_ctrl_shifter.sv
// mem_bus_shifter: WIDTH-bit register with parallel load that presents its
// top BUS_W bits as the outgoing beat and shifts a new beat in at the bottom.
module mem_bus_shifter #(
  parameter int WIDTH = 16,
  parameter int BUS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic             i_shift,
  input  logic [BUS_W-1:0] i_beatIn,
  output logic [BUS_W-1:0] o_beatOut,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // Load has priority; a shift moves the word up one beat, MSB beat first out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_loadData;
    end else if (i_shift) begin
      r_data <= (r_data << BUS_W) | WIDTH'(i_beatIn);
    end
  end

  assign o_beatOut = r_data[WIDTH-1 -: BUS_W];
  assign o_data    = r_data;

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences one memory request at a time onto a narrow bus:
// address beats, write-data beats, wait for ack, read-data beats, response.
// Optional acknowledge timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int BUS_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input logic            clk,
  input logic            rst,
  mem_bus_ctrl_if.master bus
);

  localparam int A_BEATS = ADDR_W / BUS_W;
  localparam int D_BEATS = DATA_W / BUS_W;
  localparam int CNT_W   = $clog2(maxBeats(A_BEATS, D_BEATS) + 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BEATS - 1);

  bus_state_t       r_state;
  mem_type_t        r_type;
  logic [CNT_W-1:0] r_beatCnt;

  logic              w_accept;
  logic              w_isWrite;
  logic              w_isRead;
  logic              w_timeout;
  logic              w_rspErr;
  logic              w_inAddr;
  logic              w_inWdata;
  logic              w_inRdata;
  logic [BUS_W-1:0]  w_addrBeat;
  logic [BUS_W-1:0]  w_dataBeat;
  logic [DATA_W-1:0] w_dataWord;

  assign w_accept  = bus.req_valid && (r_state == BUS_IDLE);
  assign w_isWrite = (r_type == TYPE_DMEM_WRITE);
  assign w_isRead  = (r_type == TYPE_IMEM_READ) || (r_type == TYPE_DMEM_READ);
  assign w_inAddr  = (r_state == BUS_ADDR);
  assign w_inWdata = (r_state == BUS_WDATA);
  assign w_inRdata = (r_state == BUS_RDATA);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_err;

  assign w_timeout = (r_state == BUS_WAIT_ACK) && !bus.bus_ack &&
                     (r_waitCnt == WAIT_W'(MAX_WAIT));
  assign w_rspErr  = (r_state == BUS_RESP) && r_err;

  // Count ack-less WAIT_ACK cycles; held at zero outside WAIT_ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (r_state != BUS_WAIT_ACK || bus.bus_ack || w_timeout) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  // Remember a timeout until its response has been issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_rspErr  = 1'b0;
`endif

  // Main sequencer: one state per phase, beat counter reused across phases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BUS_IDLE;
      r_type    <= TYPE_IDLE;
      r_beatCnt <= '0;
    end else begin
      case (r_state)
        BUS_IDLE: begin
          if (w_accept) begin
            r_type    <= bus.req_type;
            r_beatCnt <= '0;
            r_state   <= (bus.req_type == TYPE_IDLE) ? BUS_RESP : BUS_ADDR;
          end
        end
        BUS_ADDR: begin
          if (r_beatCnt == A_LAST) begin
            r_beatCnt <= '0;
            r_state   <= w_isWrite ? BUS_WDATA : BUS_WAIT_ACK;
          end else begin
            r_beatCnt <= r_beatCnt + 1'b1;
          end
        end
        BUS_WDATA: begin
          if (r_beatCnt == D_LAST) begin
            r_beatCnt <= '0;
            r_state   <= BUS_WAIT_ACK;
          end else begin
            r_beatCnt <= r_beatCnt + 1'b1;
          end
        end
        BUS_WAIT_ACK: begin
          if (bus.bus_ack) begin
            r_state <= w_isWrite ? BUS_RESP : BUS_RDATA;
          end else if (w_timeout) begin
            r_state <= BUS_RESP;
          end
        end
        BUS_RDATA: begin
          if (r_beatCnt == D_LAST) begin
            r_beatCnt <= '0;
            r_state   <= BUS_RESP;
          end else begin
            r_beatCnt <= r_beatCnt + 1'b1;
          end
        end
        BUS_RESP: begin
          r_state <= BUS_IDLE;
        end
        default: begin
          r_state   <= BUS_IDLE;
          r_beatCnt <= '0;
        end
      endcase
    end
  end

  mem_bus_shifter #(.WIDTH(ADDR_W), .BUS_W(BUS_W)) u_addrShift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_loadData (bus.req_addr),
    .i_shift    (w_inAddr),
    .i_beatIn   ({BUS_W{1'b0}}),
    .o_beatOut  (w_addrBeat),
    .o_data     ()
  );

  // Write data is preloaded; reads start from zero and fill up from bus_in
  mem_bus_shifter #(.WIDTH(DATA_W), .BUS_W(BUS_W)) u_dataShift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_loadData ((bus.req_type == TYPE_DMEM_WRITE) ? bus.req_wdata : {DATA_W{1'b0}}),
    .i_shift    (w_inWdata || w_inRdata),
    .i_beatIn   (w_inRdata ? bus.bus_in : {BUS_W{1'b0}}),
    .o_beatOut  (w_dataBeat),
    .o_data     (w_dataWord)
  );

  assign bus.req_ready = (r_state == BUS_IDLE);
  assign bus.busy      = (r_state != BUS_IDLE);
  assign bus.bus_oe    = w_inAddr || w_inWdata;
  assign bus.bus_out   = w_inAddr  ? w_addrBeat :
                         w_inWdata ? w_dataBeat : {BUS_W{1'b0}};
  assign bus.bus_type  = (w_inAddr || w_inWdata || w_inRdata ||
                          r_state == BUS_WAIT_ACK) ? r_type : TYPE_IDLE;
  assign bus.rsp_valid = (r_state == BUS_RESP);
  assign bus.rsp_err   = w_rspErr;
  assign bus.rsp_rdata = ((r_state == BUS_RESP) && w_isRead && !w_rspErr) ?
                         w_dataWord : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl with hand-computed expectations.
// Cycle n of a transaction is the clock period after edge n-1, where the
// request is accepted on edge 0; outputs are sampled on the falling edge.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(16), .BUS_W(4)) busIf ();

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .BUS_W(4), .MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input mem_type_t t, input logic [15:0] addr,
                               input logic [15:0] wdata);
    busIf.req_valid = 1'b1;
    busIf.req_type  = t;
    busIf.req_addr  = addr;
    busIf.req_wdata = wdata;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(busIf.req_ready), 32'd1);
    checkOutput({tag, "_rspValid"}, 32'(busIf.rsp_valid), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(busIf.rsp_rdata), 32'd0);
    checkOutput({tag, "_err"}, 32'(busIf.rsp_err), 32'd0);
    checkOutput({tag, "_type"}, 32'(busIf.bus_type), 32'(TYPE_IDLE));
    checkOutput({tag, "_out"}, 32'(busIf.bus_out), 32'd0);
    checkOutput({tag, "_oe"}, 32'(busIf.bus_oe), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busIf.busy), 32'd0);
  endtask

  // Safety net so the bench never hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rdBeats [4];
    logic [3:0] wrBeats [8];
    int rspSeen;

    rdBeats = '{4'hB, 4'hE, 4'hE, 4'hF};
    wrBeats = '{4'h0, 4'h0, 4'hA, 4'h5, 4'hC, 4'h0, 4'hD, 4'hE};
    testCount = 0;
    failCount = 0;

    rst             = 1'b1;
    busIf.req_valid = 1'b0;
    busIf.req_type  = TYPE_IDLE;
    busIf.req_addr  = '0;
    busIf.req_wdata = '0;
    busIf.bus_in    = '0;
    busIf.bus_ack   = 1'b0;
    #1;
    checkResetValues("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DMEM read, zero wait states
    applyStimulus(TYPE_DMEM_READ, 16'h1234, 16'h0);
    checkOutput("rd_ready_c0", 32'(busIf.req_ready), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      busIf.req_valid = 1'b0;
      busIf.bus_ack   = (c == 5);
      busIf.bus_in    = (c >= 6 && c <= 9) ? rdBeats[c-6] : 4'h0;
      if (c <= 4) begin
        checkOutput($sformatf("rd_out_c%0d", c), 32'(busIf.bus_out), 32'(c));
        checkOutput($sformatf("rd_oe_c%0d", c), 32'(busIf.bus_oe), 32'd1);
        checkOutput($sformatf("rd_type_c%0d", c), 32'(busIf.bus_type), 32'(TYPE_DMEM_READ));
      end
      if (c == 5) begin
        checkOutput("rd_oe_c5", 32'(busIf.bus_oe), 32'd0);
        checkOutput("rd_out_c5", 32'(busIf.bus_out), 32'd0);
        checkOutput("rd_type_c5", 32'(busIf.bus_type), 32'(TYPE_DMEM_READ));
      end
      if (c == 9) checkOutput("rd_rspValid_c9", 32'(busIf.rsp_valid), 32'd0);
      if (c == 10) begin
        checkOutput("rd_rspValid_c10", 32'(busIf.rsp_valid), 32'd1);
        checkOutput("rd_rdata_c10", 32'(busIf.rsp_rdata), 32'hBEEF);
        checkOutput("rd_err_c10", 32'(busIf.rsp_err), 32'd0);
        checkOutput("rd_type_c10", 32'(busIf.bus_type), 32'(TYPE_IDLE));
      end
    end
    busIf.bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("rd_rspValid_c11", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("rd_ready_c11", 32'(busIf.req_ready), 32'd1);

    // DMEM write, ack after three wait cycles
    applyStimulus(TYPE_DMEM_WRITE, 16'h00A5, 16'hC0DE);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      busIf.req_valid = 1'b0;
      busIf.bus_ack   = (c == 12);
      if (c <= 8) begin
        checkOutput($sformatf("wr_out_c%0d", c), 32'(busIf.bus_out), 32'(wrBeats[c-1]));
        checkOutput($sformatf("wr_oe_c%0d", c), 32'(busIf.bus_oe), 32'd1);
        checkOutput($sformatf("wr_type_c%0d", c), 32'(busIf.bus_type), 32'(TYPE_DMEM_WRITE));
      end else if (c <= 12) begin
        checkOutput($sformatf("wr_oe_c%0d", c), 32'(busIf.bus_oe), 32'd0);
        checkOutput($sformatf("wr_rspValid_c%0d", c), 32'(busIf.rsp_valid), 32'd0);
      end else begin
        checkOutput("wr_rspValid_c13", 32'(busIf.rsp_valid), 32'd1);
        checkOutput("wr_rdata_c13", 32'(busIf.rsp_rdata), 32'd0);
        checkOutput("wr_err_c13", 32'(busIf.rsp_err), 32'd0);
      end
    end
    busIf.bus_ack = 1'b0;
    @(negedge clk);
    checkOutput("wr_rspValid_c14", 32'(busIf.rsp_valid), 32'd0);

    // Back-to-back IMEM reads with request held valid and ack held high
    applyStimulus(TYPE_IMEM_READ, 16'h9ABC, 16'h0);
    busIf.bus_ack = 1'b1;
    busIf.bus_in  = 4'h7;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 11) busIf.req_addr = 16'h5678;
      if (c == 12) busIf.req_valid = 1'b0;
      if (c == 1) checkOutput("b2b_out_c1", 32'(busIf.bus_out), 32'h9);
      if (c == 10) begin
        checkOutput("b2b_rspValid_c10", 32'(busIf.rsp_valid), 32'd1);
        checkOutput("b2b_rdata_c10", 32'(busIf.rsp_rdata), 32'h7777);
        checkOutput("b2b_ready_c10", 32'(busIf.req_ready), 32'd0);
        checkOutput("b2b_oe_c10", 32'(busIf.bus_oe), 32'd0);
      end
      if (c == 11) begin
        checkOutput("b2b_ready_c11", 32'(busIf.req_ready), 32'd1);
        checkOutput("b2b_rspValid_c11", 32'(busIf.rsp_valid), 32'd0);
        checkOutput("b2b_type_c11", 32'(busIf.bus_type), 32'(TYPE_IDLE));
        checkOutput("b2b_oe_c11", 32'(busIf.bus_oe), 32'd0);
      end
      if (c == 12) begin
        checkOutput("b2b_busy_c12", 32'(busIf.busy), 32'd1);
        checkOutput("b2b_out_c12", 32'(busIf.bus_out), 32'h5);
        checkOutput("b2b_type_c12", 32'(busIf.bus_type), 32'(TYPE_IMEM_READ));
      end
      if (c == 21) begin
        checkOutput("b2b_rspValid_c21", 32'(busIf.rsp_valid), 32'd1);
        checkOutput("b2b_rdata_c21", 32'(busIf.rsp_rdata), 32'h7777);
      end
      if (c == 22) begin
        checkOutput("b2b_rspValid_c22", 32'(busIf.rsp_valid), 32'd0);
        checkOutput("b2b_ready_c22", 32'(busIf.req_ready), 32'd1);
      end
    end
    busIf.bus_ack = 1'b0;
    busIf.bus_in  = 4'h0;

    // TYPE_IDLE request answers immediately without touching the bus
    applyStimulus(TYPE_IDLE, 16'h0FFF, 16'hFFFF);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    checkOutput("idle_rspValid_c1", 32'(busIf.rsp_valid), 32'd1);
    checkOutput("idle_rdata_c1", 32'(busIf.rsp_rdata), 32'd0);
    checkOutput("idle_oe_c1", 32'(busIf.bus_oe), 32'd0);
    checkOutput("idle_type_c1", 32'(busIf.bus_type), 32'(TYPE_IDLE));
    checkOutput("idle_busy_c1", 32'(busIf.busy), 32'd1);
    @(negedge clk);
    checkOutput("idle_rspValid_c2", 32'(busIf.rsp_valid), 32'd0);
    checkOutput("idle_busy_c2", 32'(busIf.busy), 32'd0);

    // Read that never sees an acknowledge
    applyStimulus(TYPE_DMEM_READ, 16'h4321, 16'h0);
    busIf.bus_in = 4'hF;
    rspSeen = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      busIf.req_valid = 1'b0;
      if (busIf.rsp_valid) rspSeen++;
`ifdef MEM_BUS_TIMEOUT_EN
      if (c == 20) checkOutput("to_rspValid_c20", 32'(busIf.rsp_valid), 32'd0);
      if (c == 21) begin
        checkOutput("to_rspValid_c21", 32'(busIf.rsp_valid), 32'd1);
        checkOutput("to_err_c21", 32'(busIf.rsp_err), 32'd1);
        checkOutput("to_rdata_c21", 32'(busIf.rsp_rdata), 32'd0);
      end
`endif
    end
`ifdef MEM_BUS_TIMEOUT_EN
    checkOutput("to_rspCount", 32'(rspSeen), 32'd1);
    checkOutput("to_busy_c100", 32'(busIf.busy), 32'd0);
`else
    checkOutput("noack_rspCount", 32'(rspSeen), 32'd0);
    checkOutput("noack_busy_c100", 32'(busIf.busy), 32'd1);
    checkOutput("noack_oe_c100", 32'(busIf.bus_oe), 32'd0);
`endif
    busIf.bus_in = 4'h0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of the write-data phase
    applyStimulus(TYPE_DMEM_WRITE, 16'h00A5, 16'hC0DE);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      busIf.req_valid = 1'b0;
    end
    checkOutput("rst_out_c7", 32'(busIf.bus_out), 32'hD);
    #2 rst = 1'b1;
    #1;
    checkResetValues("rstMid");
    @(negedge clk);
    rst = 1'b0;
    busIf.bus_ack = 1'b1;
    rspSeen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busIf.rsp_valid) rspSeen++;
    end
    busIf.bus_ack = 1'b0;
    checkOutput("rst_rspCount", 32'(rspSeen), 32'd0);
    checkOutput("rst_ready_after", 32'(busIf.req_ready), 32'd1);
    checkOutput("rst_busy_after", 32'(busIf.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
